// File: rtl/sipo_deserializer.sv
// Receive end of the 2-bit serial link: collects LSB-first chunks into a
// parallel word and holds it in a one-entry output stage with valid/ready.
module sipo_deserializer #(
  parameter int SIZE_DATA_IN  = 2,
  parameter int SIZE_DATA_OUT = 16,
  parameter int DEPTH         = SIZE_DATA_OUT / SIZE_DATA_IN,
  parameter int SIZE_DEPTH    = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [SIZE_DATA_IN-1:0]  i_data,
  input  logic                     i_clear,
  input  logic                     i_ready,
  output logic [SIZE_DATA_OUT-1:0] o_data,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_overflow
);

  localparam logic [SIZE_DEPTH-1:0] LAST_SLOT = SIZE_DEPTH'(DEPTH - 1);

  logic [SIZE_DATA_OUT-1:0] r_asm;
  logic [SIZE_DEPTH-1:0]    r_count;
  logic [SIZE_DATA_OUT-1:0] r_out;
  logic                     r_valid;
  logic                     r_overflow;

  logic                     w_accept;
  logic                     w_complete;
  logic                     w_drain;
  logic                     w_load;
  logic                     w_drop;
  logic [SIZE_DATA_OUT-1:0] w_asm_next;

  // Handshake: a word transfers on the rising edge where o_valid=1 and
  // i_ready=1; o_valid never drops without such a transfer (except reset).
  assign w_accept   = i_valid & ~i_clear;
  assign w_complete = w_accept & (r_count == LAST_SLOT);
  assign w_drain    = r_valid & i_ready;
  assign w_load     = w_complete & (~r_valid | i_ready);
  assign w_drop     = w_complete & r_valid & ~i_ready;

  always_comb begin
    w_asm_next = r_asm;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_count == SIZE_DEPTH'(k)) begin
        w_asm_next[k*SIZE_DATA_IN +: SIZE_DATA_IN] = i_data;
      end
    end
  end

  // asm is never cleared except by reset: stale slots are rewritten before
  // the next completion, so clearing would only cost logic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_asm   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_valid) begin
      r_asm   <= w_asm_next;
      r_count <= r_count + SIZE_DEPTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_out   <= w_asm_next;
      r_valid <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_data     = r_valid ? r_out : '0;
  assign o_valid    = r_valid;
  assign o_busy     = (r_count != '0);
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: scoreboard of expected words
// popped on each handshake transfer, plus directed latency/flag checks.
module tb_sipo_deserializer;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [1:0]  i_data;
  logic        i_clear;
  logic        i_ready;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_busy;
  logic        o_overflow;

  int tests_run;
  int tests_failed;
  int cyc;
  int busy_cnt;
  int pop_cnt;
  int last_pop_cyc;
  int prev_pop_cyc;
  logic [15:0] exp_q[$];

  sipo_deserializer dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_clear    (i_clear),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: a transfer is o_valid & i_ready at the coming edge
  always @(negedge clk) begin
    if (o_busy) busy_cnt++;
    if (rst_n && o_valid && i_ready) begin
      check("sb_word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("sb_data", {16'd0, o_data}, {16'd0, exp_q.pop_front()});
      pop_cnt++;
      prev_pop_cyc = last_pop_cyc;
      last_pop_cyc = cyc;
    end
  end

  // driver tasks
  task automatic send_chunk(input logic [1:0] d, input logic clr);
    @(posedge clk); #1;
    i_valid = 1'b1;
    i_data  = d;
    i_clear = clr;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 8; i++) send_chunk(w[2*i +: 2], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_clear = 1'b0;
    end
  endtask

  initial begin
    int pops_before;
    tests_run = 0; tests_failed = 0; cyc = 0; busy_cnt = 0;
    pop_cnt = 0; last_pop_cyc = 0; prev_pop_cyc = 0;
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_clear = 1'b0; i_ready = 1'b1;
    #1;
    check("rst_data", {16'd0, o_data}, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_ovf", {31'd0, o_overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single word
    busy_cnt = 0;
    exp_q.push_back(16'hB4E1);
    send_word(16'hB4E1);
    idle(1);
    check("t1_valid", {31'd0, o_valid}, 32'd1);
    check("t1_data", {16'd0, o_data}, 32'h0000B4E1);
    idle(1);
    check("t1_valid_pulse", {31'd0, o_valid}, 32'd0);
    check("t1_data_zero", {16'd0, o_data}, 32'd0);
    check("t1_busy_cycles", busy_cnt, 32'd7);

    // back-to-back
    pops_before = pop_cnt;
    exp_q.push_back(16'hB4E1);
    exp_q.push_back(16'h1234);
    send_word(16'hB4E1);
    send_word(16'h1234);
    idle(3);
    check("t2_pops", pop_cnt - pops_before, 32'd2);
    check("t2_gap", last_pop_cyc - prev_pop_cyc, 32'd8);
    check("t2_ovf", {31'd0, o_overflow}, 32'd0);

    // backpressure and overflow
    i_ready = 1'b0;
    exp_q.push_back(16'hB4E1);
    send_word(16'hB4E1);
    send_word(16'hFFFF);
    idle(1);
    check("t3_ovf", {31'd0, o_overflow}, 32'd1);
    check("t3_valid", {31'd0, o_valid}, 32'd1);
    check("t3_data_held", {16'd0, o_data}, 32'h0000B4E1);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("t3_drain_valid", {31'd0, o_valid}, 32'd0);
    check("t3_drain_data", {16'd0, o_data}, 32'd0);
    check("t3_ovf_sticky", {31'd0, o_overflow}, 32'd1);
    i_ready = 1'b1;

    // clear mid-word
    send_chunk(2'd3, 1'b0);
    send_chunk(2'd3, 1'b0);
    send_chunk(2'd3, 1'b0);
    send_chunk(2'd3, 1'b1);
    idle(1);
    check("t4_busy_after_clear", {31'd0, o_busy}, 32'd0);
    check("t4_ovf_cleared", {31'd0, o_overflow}, 32'd0);
    exp_q.push_back(16'hB4E1);
    send_word(16'hB4E1);
    idle(1);
    check("t4_data", {16'd0, o_data}, 32'h0000B4E1);
    idle(2);
    check("t4_q_empty", exp_q.size(), 32'd0);

    // gapped input
    exp_q.push_back(16'h00AA);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] w;
      w = 16'h00AA;
      send_chunk(w[2*i +: 2], 1'b0);
      idle(1);
      if (i < 7) check("t5_no_early_valid", {31'd0, o_valid}, 32'd0);
    end
    check("t5_valid", {31'd0, o_valid}, 32'd1);
    check("t5_data", {16'd0, o_data}, 32'h000000AA);
    idle(2);

    // reset mid-word
    for (int i = 0; i < 5; i++) send_chunk(2'($urandom_range(0, 3)), 1'b0);
    idle(1);
    check("t6_busy_pre", {31'd0, o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", {31'd0, o_busy}, 32'd0);
    check("t6_rst_valid", {31'd0, o_valid}, 32'd0);
    check("t6_rst_data", {16'd0, o_data}, 32'd0);
    check("t6_rst_ovf", {31'd0, o_overflow}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(16'hB4E1);
    send_word(16'hB4E1);
    idle(1);
    check("t6_valid", {31'd0, o_valid}, 32'd1);
    check("t6_data", {16'd0, o_data}, 32'h0000B4E1);
    idle(3);
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in/parallel-out deserializer: the receive end of the team's 2-bit serial link. It accepts SIZE_DATA_IN-bit chunks qualified by a valid strobe, least-significant chunk first, and assembles them into SIZE_DATA_OUT-bit words. Each completed word is presented on a registered output with a valid/ready handshake. It sits downstream of the PISO serializer and restores the original parallel word.

## Interface
- SIZE_DATA_IN, default 2: chunk width.
- SIZE_DATA_OUT, default 16: assembled word width. Must be an integer multiple of SIZE_DATA_IN.
- DEPTH, derived as SIZE_DATA_OUT/SIZE_DATA_IN (8 by default): chunks per word. Must be a power of 2, at least 2.
- SIZE_DEPTH, derived as $clog2(DEPTH): counter width.
- i_clk  input  1  single clock; all logic on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  i_data carries a valid chunk this cycle.
- i_data  input  SIZE_DATA_IN  serial chunk.
- i_clear  input  1  synchronous resync: discards the partial word and clears o_overflow.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_data  output  SIZE_DATA_OUT  assembled word; forced to 0 whenever o_valid=0.
- o_valid  output  1  o_data holds an unconsumed word.
- o_busy  output  1  a partial word is in progress (count != 0).
- o_overflow  output  1  sticky: a completed word was dropped.

## Operation
- Assembly register `asm` and counter `count` (SIZE_DEPTH bits).
  - On i_valid=1 with i_clear=0: write `asm[count*SIZE_DATA_IN +: SIZE_DATA_IN] <= i_data`, then `count <= count+1`.
  - `count` wraps from DEPTH-1 to 0.
- Word completion: i_valid=1 and count==DEPTH-1. The completed word is the `asm` contents with the current chunk merged in at the top slice.
- Output register `out_reg` plus o_valid form a one-entry holding stage:
  - Slot free (o_valid=0), or slot drained this cycle (o_valid=1 and i_ready=1): a completion loads `out_reg` and o_valid stays or becomes 1.
  - Drain without completion: o_valid goes to 0.
  - Completion while o_valid=1 and i_ready=0: the new word is dropped, `out_reg` is unchanged, and o_overflow is set next cycle. `count` still wraps to 0.
- i_clear=1 has priority over i_valid in the same cycle:
  - The chunk is dropped, `count` goes to 0, and o_overflow goes to 0.
  - `out_reg`, o_valid and the handshake are unaffected.
- `asm` is not cleared on completion or on i_clear. Stale bits are overwritten before the next completion.
- Gaps in i_valid are legal at any point; the word continues to assemble across them.
- o_data equals `out_reg` when o_valid=1, and 0 otherwise.

## Timing
- Reset (i_rst_n=0, asynchronous): count=0, asm=0, out_reg=0, o_valid=0, o_data=0, o_busy=0, o_overflow=0.
- Reset asserted mid-word discards the partial word immediately. The first chunk after release is slot 0.
- Latency: the word is visible on o_data with o_valid=1 in the cycle after the edge that samples the last chunk (1 cycle).
- Throughput: one chunk per cycle. Back-to-back words with i_ready held at 1 give one o_valid pulse every DEPTH cycles, with no bubbles needed.
- The handshake transfers on the rising edge where o_valid=1 and i_ready=1.
- o_valid never drops without a transfer, except on reset.
- o_busy is registered from `count` and is 1 from the cycle after the first chunk until the cycle after the last chunk.
- o_overflow is set or cleared on the edge following the causing event.

## Test plan
- **Single word:** reset, then chunks 1,0,2,3,0,1,3,2 on 8 consecutive cycles with i_ready=1. Expect o_data=0xB4E1 with o_valid=1 for exactly 1 cycle, one cycle after the last chunk. o_busy is high for 7 cycles.
- **Back-to-back words:** send 0xB4E1 then 0x1234 with no gap and i_ready=1. Expect o_valid pulses 8 cycles apart carrying 0xB4E1 then 0x1234, and o_overflow=0.
- **Backpressure and overflow:** i_ready=0 throughout, send 0xB4E1 then 0xFFFF. Expect o_data held at 0xB4E1 with o_valid=1, and o_overflow=1 the cycle after the 16th chunk. Then raise i_ready for 1 cycle: o_valid goes to 0 and o_data to 0.
- **Clear mid-word:** send 3 chunks of 0xFFFF (3,3,3), then pulse i_clear together with i_valid=1 and data 3, then send 0xB4E1. Expect only 0xB4E1 to be output, and o_busy=0 right after the clear.
- **Gapped input:** send 0x00AA chunks with i_valid toggling every other cycle. Expect o_data=0x00AA once, one cycle after the 8th valid chunk.
- **Reset mid-word:** after 5 chunks, assert i_rst_n=0 for 1 cycle. Expect all outputs 0 immediately. Then send 0xB4E1 and expect a correct 0xB4E1 output.
